// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master (addr/data/start/done) among NUM_REQ requesters.
// Optional watchdog with DRAIN state enabled by defining AXI_ARB_TIMEOUT_EN.
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ-1:0]                 i_req_we,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [NUM_REQ-1:0]                 o_rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]          o_rsp_data,
  output logic                               o_rsp_fault,
  output logic [AXI_ADDR_WIDTH-1:0]          o_addr_master,
  output logic [AXI_DATA_WIDTH-1:0]          o_data_master,
  output logic                               o_start_write,
  output logic                               o_start_read,
  input  logic [AXI_DATA_WIDTH-1:0]          i_data_master,
  input  logic                               i_done,
  input  logic                               i_read_fault,
  input  logic                               i_write_fault,
  output logic [2:0]                         o_dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi4_lite_req_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3
`ifdef AXI_ARB_TIMEOUT_EN
    ,
    S_DRAIN = 3'd4
`endif
  } state_e;

  state_e                    state_q;
  logic [PTR_W-1:0]          ptr_q;
  logic [PTR_W-1:0]          gnt_q;
  logic                      we_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q;
  logic                      rsp_fault_q;
`ifdef AXI_ARB_TIMEOUT_EN
  logic [31:0]               wdog_q;
  logic                      timed_out_q;
`endif

  logic [PTR_W-1:0]          gnt_d;
  logic [PTR_W-1:0]          ptr_d;
  logic [PTR_W-1:0]          cand;
  logic                      gnt_found;
  logic                      take;

  // First pending requester at or above the pointer, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_d     = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + 32'(i)) % 32'(NUM_REQ));
      if (!gnt_found && i_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_d     = cand;
      end
    end
    ptr_d = PTR_W'((32'(gnt_d) + 32'd1) % 32'(NUM_REQ));
  end

  // Ready is gated by reset so no acceptance is signalled while held in reset.
  assign take = arst && (state_q == S_IDLE) && gnt_found;

  always_comb begin
    o_req_ready = '0;
    if (take) o_req_ready[gnt_d] = 1'b1;
  end

  always_comb begin
    o_rsp_valid = '0;
    if (state_q == S_RESP) o_rsp_valid[gnt_q] = 1'b1;
  end

  assign o_start_write = (state_q == S_ISSUE) &&  we_q;
  assign o_start_read  = (state_q == S_ISSUE) && !we_q;
  assign o_addr_master = addr_q;
  assign o_data_master = data_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_fault   = rsp_fault_q;
  assign o_dbg_state   = state_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
`ifdef AXI_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            gnt_q   <= gnt_d;
            we_q    <= i_req_we[gnt_d];
            addr_q  <= i_req_addr[gnt_d*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            data_q  <= i_req_data[gnt_d*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            ptr_q   <= ptr_d;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef AXI_ARB_TIMEOUT_EN
          wdog_q      <= '0;
          timed_out_q <= 1'b0;
`endif
        end
        S_WAIT: begin
          // A done arriving on the limit cycle still yields a normal response.
          if (i_done) begin
            rsp_data_q  <= we_q ? '0 : i_data_master;
            rsp_fault_q <= we_q ? i_write_fault : i_read_fault;
            state_q     <= S_RESP;
          end
`ifdef AXI_ARB_TIMEOUT_EN
          else if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b1;
            timed_out_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wdog_q <= wdog_q + 32'd1;
          end
`endif
        end
        S_RESP: begin
`ifdef AXI_ARB_TIMEOUT_EN
          state_q <= timed_out_q ? S_DRAIN : S_IDLE;
`else
          state_q <= S_IDLE;
`endif
        end
`ifdef AXI_ARB_TIMEOUT_EN
        S_DRAIN: begin
          // The abandoned transaction's late done is swallowed here.
          if (i_done) state_q <= S_IDLE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed testbench for axi4_lite_req_arbiter: hand-computed vectors checked with immediate assertions.
module tb_axi4_lite_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 64;
  localparam int DW = 32;

  logic              clk;
  logic              arst;
  logic [NR-1:0]     i_req_valid;
  logic [NR-1:0]     i_req_we;
  logic [NR*AW-1:0]  i_req_addr;
  logic [NR*DW-1:0]  i_req_data;
  logic [NR-1:0]     o_req_ready;
  logic [NR-1:0]     o_rsp_valid;
  logic [DW-1:0]     o_rsp_data;
  logic              o_rsp_fault;
  logic [AW-1:0]     o_addr_master;
  logic [DW-1:0]     o_data_master;
  logic              o_start_write;
  logic              o_start_read;
  logic [DW-1:0]     i_data_master;
  logic              i_done;
  logic              i_read_fault;
  logic              i_write_fault;
  logic [2:0]        o_dbg_state;

  int errors = 0;
  int checks = 0;

  axi4_lite_req_arbiter #(
    .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .arst(arst),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid),
    .o_rsp_data(o_rsp_data), .o_rsp_fault(o_rsp_fault),
    .o_addr_master(o_addr_master), .o_data_master(o_data_master),
    .o_start_write(o_start_write), .o_start_read(o_start_read),
    .i_data_master(i_data_master), .i_done(i_done),
    .i_read_fault(i_read_fault), .i_write_fault(i_write_fault),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_req_valid[k] = 1'b1;
    i_req_we[k]    = we;
    i_req_addr[k*AW +: AW] = a;
    i_req_data[k*DW +: DW] = d;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(o_req_ready), 64'h0);
    check({tag, "_rspv"},  64'(o_rsp_valid), 64'h0);
    check({tag, "_rspd"},  64'(o_rsp_data), 64'h0);
    check({tag, "_rspf"},  64'(o_rsp_fault), 64'h0);
    check({tag, "_addr"},  o_addr_master, 64'h0);
    check({tag, "_data"},  64'(o_data_master), 64'h0);
    check({tag, "_start"}, {62'h0, o_start_write, o_start_read}, 64'h0);
    check({tag, "_state"}, 64'(o_dbg_state), 64'h0);
  endtask

  // Entered in an IDLE cycle with the requests already driven; leaves in the following IDLE cycle.
  task automatic run_txn(input string tag, input int g, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] rdata, input logic rf, input logic wf,
                         input int delay, input bit drop);
    logic [NR-1:0] onehot;
    onehot = 4'b0001 << g;
    #1;
    check({tag, "_grant"}, 64'(o_req_ready), 64'(onehot));
    tick();
    if (drop) begin
      i_req_valid[g] = 1'b0;
      i_req_we[g]    = ~i_req_we[g];
      i_req_addr[g*AW +: AW] = ~i_req_addr[g*AW +: AW];
      i_req_data[g*DW +: DW] = ~i_req_data[g*DW +: DW];
    end
    #1;
    check({tag, "_issue_ready"}, 64'(o_req_ready), 64'h0);
    check({tag, "_start_wr"}, 64'(o_start_write), 64'(we));
    check({tag, "_start_rd"}, 64'(o_start_read), 64'(!we));
    check({tag, "_addr"}, o_addr_master, addr);
    check({tag, "_wdata"}, 64'(o_data_master), 64'(wdata));
    tick();
    check({tag, "_wait_start"}, {62'h0, o_start_write, o_start_read}, 64'h0);
    for (int d = 0; d < delay; d++) begin
      check({tag, "_wait_rspv"}, 64'(o_rsp_valid), 64'h0);
      check({tag, "_wait_wdata"}, 64'(o_data_master), 64'(wdata));
      tick();
    end
    i_done = 1'b1; i_data_master = rdata; i_read_fault = rf; i_write_fault = wf;
    tick();
    i_done = 1'b0; i_data_master = 32'h0BAD_0BAD; i_read_fault = 1'b1; i_write_fault = 1'b1;
    #1;
    check({tag, "_rspv"}, 64'(o_rsp_valid), 64'(onehot));
    check({tag, "_rspd"}, 64'(o_rsp_data), we ? 64'h0 : 64'(rdata));
    check({tag, "_rspf"}, 64'(o_rsp_fault), we ? 64'(wf) : 64'(rf));
    check({tag, "_resp_ready"}, 64'(o_req_ready), 64'h0);
    tick();
    i_read_fault = 1'b0; i_write_fault = 1'b0;
    check({tag, "_after_rspv"}, 64'(o_rsp_valid), 64'h0);
    check({tag, "_hold_rspd"}, 64'(o_rsp_data), we ? 64'h0 : 64'(rdata));
  endtask

  initial begin
    arst = 1'b0;
    i_req_valid = '0; i_req_we = '0; i_req_addr = '0; i_req_data = '0;
    i_data_master = '0; i_done = 1'b0; i_read_fault = 1'b0; i_write_fault = 1'b0;

    // Reset with all four requesting: nothing may be accepted.
    set_req(0, 1'b0, 64'hA000_0000_0000_0000, 32'hC0DE_0000);
    set_req(1, 1'b1, 64'hA000_0000_0000_0010, 32'hC0DE_0001);
    set_req(2, 1'b0, 64'hA000_0000_0000_0020, 32'hC0DE_0002);
    set_req(3, 1'b1, 64'hA000_0000_0000_0030, 32'hC0DE_0003);
    repeat (3) tick();
    check_all_zero("reset");
    arst = 1'b1;

    // Contention: order 0,1,2,3,0 with all requests held.
    run_txn("rr0", 0, 1'b0, 64'hA000_0000_0000_0000, 32'hC0DE_0000, 32'h1111_0000, 1'b0, 1'b0, 1, 0);
    run_txn("rr1", 1, 1'b1, 64'hA000_0000_0000_0010, 32'hC0DE_0001, 32'h1111_0001, 1'b0, 1'b0, 0, 0);
    run_txn("rr2", 2, 1'b0, 64'hA000_0000_0000_0020, 32'hC0DE_0002, 32'h1111_0002, 1'b0, 1'b0, 2, 0);
    run_txn("rr3", 3, 1'b1, 64'hA000_0000_0000_0030, 32'hC0DE_0003, 32'h1111_0003, 1'b0, 1'b0, 0, 0);
    run_txn("rr4", 0, 1'b0, 64'hA000_0000_0000_0000, 32'hC0DE_0000, 32'h1111_0004, 1'b0, 1'b0, 0, 0);
    i_req_valid = '0;

    // Single read, done five cycles after start.
    set_req(0, 1'b0, 64'h1000, 32'h0);
    run_txn("rd", 0, 1'b0, 64'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 1);
    check("idle_no_grant", 64'(o_req_ready), 64'h0);

    // Single write: read data and read fault must be ignored.
    set_req(2, 1'b1, 64'h20, 32'h1234_5678);
    run_txn("wr", 2, 1'b1, 64'h20, 32'h1234_5678, 32'hAAAA_5555, 1'b1, 1'b0, 3, 1);

    // Fault paths.
    set_req(3, 1'b0, 64'h3000, 32'h0);
    run_txn("rdflt", 3, 1'b0, 64'h3000, 32'h0, 32'h0000_5A5A, 1'b1, 1'b0, 1, 1);
    set_req(0, 1'b1, 64'h4000, 32'hFEED_0001);
    run_txn("wrok", 0, 1'b1, 64'h4000, 32'hFEED_0001, 32'h7777_7777, 1'b1, 1'b0, 1, 1);
    set_req(1, 1'b1, 64'h5000, 32'hFEED_0002);
    run_txn("wrflt", 1, 1'b1, 64'h5000, 32'hFEED_0002, 32'h0, 1'b0, 1'b1, 0, 1);

    // Reset mid-operation: pointer sits at 2 after granting req1.
    set_req(1, 1'b0, 64'h6000, 32'h0);
    #1;
    check("mid_grant", 64'(o_req_ready), 64'h2);
    tick();
    i_req_valid = '0;
    tick();
    tick();
    check("mid_in_wait", 64'(o_dbg_state), 64'h2);
    #4;
    arst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    set_req(1, 1'b0, 64'h7010, 32'h0);
    set_req(3, 1'b1, 64'h7030, 32'hBEEF_0003);
    i_done = 1'b1; i_data_master = 32'h1357_9BDF;
    tick();
    check("mid_reset_rspv", 64'(o_rsp_valid), 64'h0);
    check("mid_reset_ready", 64'(o_req_ready), 64'h0);
    arst = 1'b1;
    i_done = 1'b0;
    run_txn("post_rst1", 1, 1'b0, 64'h7010, 32'h0, 32'h2468_ACE0, 1'b0, 1'b0, 1, 1);
    run_txn("post_rst3", 3, 1'b1, 64'h7030, 32'hBEEF_0003, 32'h0, 1'b0, 1'b0, 1, 1);

`ifdef AXI_ARB_TIMEOUT_EN
    begin
      int waits;
      set_req(0, 1'b0, 64'h8000, 32'h0);
      #1;
      check("to_grant", 64'(o_req_ready), 64'h1);
      tick();
      i_req_valid = '0;
      tick();
      waits = 0;
      while (o_rsp_valid == '0 && waits < 40) begin
        waits++;
        tick();
      end
      check("to_wait_cycles", 64'(waits), 64'd16);
      check("to_rspv", 64'(o_rsp_valid), 64'h1);
      check("to_rspf", 64'(o_rsp_fault), 64'h1);
      check("to_rspd", 64'(o_rsp_data), 64'h0);
      set_req(2, 1'b0, 64'h9000, 32'h0);
      tick();
      for (int d = 0; d < 3; d++) begin
        check("drain_state", 64'(o_dbg_state), 64'h4);
        check("drain_no_grant", 64'(o_req_ready), 64'h0);
        tick();
      end
      i_done = 1'b1; i_data_master = 32'hFFFF_FFFF;
      #1;
      check("drain_done_no_grant", 64'(o_req_ready), 64'h0);
      tick();
      i_done = 1'b0;
      check("drain_rspv", 64'(o_rsp_valid), 64'h0);
      run_txn("after_drain", 2, 1'b0, 64'h9000, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 1, 1);
    end
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
- Round-robin arbiter sharing one axi4_lite_master port (addr/data/start/done interface) between NUM_REQ requesters.
- Accepts one request, issues a single-cycle start pulse to the master, waits for done, and returns data and fault to the granted requester.
- At most one transaction is outstanding. Sits between client logic and the master side of the AXI4-Lite top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with AXI_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- arst  in  1  asynchronous reset, active-low.
- i_req_valid  in  NUM_REQ  per-requester request pending.
- i_req_we  in  NUM_REQ  1 = write, 0 = read.
- i_req_addr  in  NUM_REQ*AXI_ADDR_WIDTH  packed addresses; requester k occupies slice k.
- i_req_data  in  NUM_REQ*AXI_DATA_WIDTH  packed write data.
- o_req_ready  out  NUM_REQ  one-hot, 1-cycle acceptance pulse.
- o_rsp_valid  out  NUM_REQ  one-hot, 1-cycle response pulse.
- o_rsp_data  out  AXI_DATA_WIDTH  read data, shared bus.
- o_rsp_fault  out  1  fault for the current response.
- o_addr_master  out  AXI_ADDR_WIDTH  to master i_addr.
- o_data_master  out  AXI_DATA_WIDTH  to master i_data.
- o_start_write  out  1  to master i_start_write.
- o_start_read  out  1  to master i_start_read.
- i_data_master  in  AXI_DATA_WIDTH  from master o_data.
- i_done  in  1  from master o_done.
- i_read_fault  in  1  from master o_read_fault.
- i_write_fault  in  1  from master o_write_fault.

Behaviour:
- Reset values (arst low, asynchronous): all outputs 0, state IDLE, round-robin pointer 0, latched request cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any i_req_valid is set, grant index g.
  - g is the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Latch addr, data and we for g.
  - Pulse o_req_ready[g] for one cycle (combinational with the IDLE cycle in which the grant is taken).
  - Set pointer to (g+1) mod NUM_REQ and go to ISSUE.
  - With no requests pending, stay in IDLE.
- ISSUE: exactly one cycle.
  - Assert o_start_write if we=1, otherwise o_start_read; never both.
  - o_addr_master and o_data_master are driven from the latched values and held stable from ISSUE until leaving WAIT.
  - Go to WAIT.
- WAIT: stay until i_done=1. i_done is ignored in every other state.
  - On done: register o_rsp_data = i_data_master for reads, 0 for writes.
  - Register o_rsp_fault = i_write_fault for writes, i_read_fault for reads.
  - Go to RESP.
- RESP: o_rsp_valid[g]=1 for exactly one cycle, data and fault valid, then go to IDLE.
  - o_rsp_data and o_rsp_fault hold their values until the next response.
- Latency:
  - Grant (cycle 0) to start pulse: cycle 1.
  - Done sampled in cycle n to o_rsp_valid: cycle n+1.
  - Minimum 4 cycles between consecutive grants.
- Simultaneous requests: round-robin fairness. Each requester holding valid is served within NUM_REQ grants.
- A requester may change addr/data/we freely after its ready pulse.
- A requester dropping valid before its grant forfeits the request; no other effect.
- Reset mid-operation: the transaction is abandoned and no response is issued. The system resets the master on the same arst.
- Requests in the same cycle as o_rsp_valid are not granted until the next IDLE cycle.

Optional Feature:
- Macro: AXI_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without i_done: respond with o_rsp_fault=1 and o_rsp_data=0 (via RESP), then enter DRAIN.
  - DRAIN waits for i_done, discards it, then returns to IDLE. No grants are made in DRAIN.
  - If i_done arrives in the cycle the counter hits the limit, done wins and a normal response is issued.
- Undefined: no counter and no DRAIN state; WAIT waits indefinitely.

Test Plan:
- Single read: req0 valid, we=0, addr=0x1000; master done 5 cycles after start with data 0xDEADBEEF.
  - Required: o_req_ready[0] in cycle 0, o_start_read in cycle 1, o_rsp_valid[0] with data 0xDEADBEEF and fault 0.
- Single write: req2, addr=0x20, data=0x12345678.
  - Required: o_start_write pulsed once, o_data_master=0x12345678 held through WAIT, o_rsp_valid[2] with o_rsp_data=0.
- Contention: all 4 valid continuously from reset.
  - Required: grants in order 0,1,2,3,0; no requester granted twice before the others are served.
- Fault path: read with i_read_fault=1 at done.
  - Required: o_rsp_fault=1. A following write with no fault returns o_rsp_fault=0.
- Reset mid-op: arst low during WAIT.
  - Required: all outputs 0 immediately, no o_rsp_valid. After release, pointer=0 and req1+req3 pending grants req1 first.
- Timeout (AXI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no done.
  - Required: o_rsp_valid with fault=1 after 16 WAIT cycles. A late i_done is discarded, then the next request is granted normally.
